// File: rtl/demux6_stream_reg.sv
// demux6_stream_reg
//   Registered 1-to-6 stream demultiplexer. One input stream is steered to one
//   of six output channels by sel. Each channel has a one-entry holding register
//   with a valid/ready handshake. Select codes 6 and 7 consume and discard the
//   beat and bump a saturating drop counter.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   sel        destination channel (0..5 legal, 6/7 drop)
//   in_data    input beat data
//   in_valid   input beat present
//   in_ready   beat accepted this cycle (function of sel, channel state, out_ready)
//   out_data   channel i at [WIDTH*i +: WIDTH], straight from its holding register
//   out_valid  bit i: channel i holds a beat
//   out_ready  bit i: channel i consumer takes the beat this cycle
//   drop_cnt   saturating count of beats discarded for sel 6/7
module demux6_stream_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [6*WIDTH-1:0] out_data,
  output logic [5:0]         out_valid,
  input  logic [5:0]         out_ready,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [WIDTH-1:0] data_q [6];
  logic [5:0]       valid_q;
  logic [CNT_W-1:0] drop_q;

  logic       sel_legal;
  logic [5:0] push;
  logic [5:0] pop;
  logic       drop;

  // A full channel still accepts when its consumer pops in the same cycle,
  // so a single channel sustains one beat per clock.
  always_comb begin
    sel_legal = (sel < 3'd6);
    in_ready  = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (sel == 3'(i)) begin
        in_ready = ~valid_q[i] | out_ready[i];
      end
    end
  end

  always_comb begin
    push = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      push[i] = in_valid & in_ready & (sel == 3'(i));
    end
    pop  = valid_q & out_ready;
    drop = in_valid & ~sel_legal;
  end

  // Push wins over pop: simultaneous pop+push leaves the channel full with new data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        if (push[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= in_data;
        end else if (pop[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      out_data[WIDTH*i +: WIDTH] = data_q[i];
    end
  end

  assign out_valid = valid_q;
  assign drop_cnt  = drop_q;

endmodule
